// File: rtl/fir_decim_pwm_if.sv
// Sample-path bundle between the FIR output stage and its decimating rescaler.
// The master drives the strobe and the FIR word; the slave returns the rescaled sample and the PWM bit.
interface fir_decim_pwm_if;
    logic               ready_in;
    logic signed [17:0] y_in;
    logic signed [7:0]  sample_out;
    logic               sample_valid_out;
    logic               clip_out;
    logic               pwm_out;

    modport master (
        output ready_in, y_in,
        input  sample_out, sample_valid_out, clip_out, pwm_out
    );

    modport slave (
        input  ready_in, y_in,
        output sample_out, sample_valid_out, clip_out, pwm_out
    );
endinterface

// File: rtl/fir_decim_pwm.sv
// Decimates the 18-bit FIR output by DECIM, rescales by 2**SHIFT with round-half-up and 8-bit saturation.
// Define PWM_OUT_EN to build the glitch-free 8-bit PWM audio output; otherwise pwm_out is tied low.
module fir_decim_pwm #(
    parameter int DECIM = 4,
    parameter int SHIFT = 10
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    fir_decim_pwm_if.slave io
);

    localparam int DATA_W = 18;
    localparam int OUT_W  = 8;

    localparam logic [3:0]              DCNT_LAST = 4'(DECIM - 1);
    localparam logic signed [DATA_W:0]  RND       = (DATA_W + 1)'(64'd1 << (SHIFT - 1));
    localparam logic signed [DATA_W:0]  QMAX      = (DATA_W + 1)'(127);
    localparam logic signed [DATA_W:0]  QMIN      = -(DATA_W + 1)'(128);

    // One extra bit of headroom so adding the half-LSB can never overflow.
    function automatic logic signed [DATA_W:0] round_shift(input logic signed [DATA_W-1:0] y);
        logic signed [DATA_W:0] r;
        r = {y[DATA_W-1], y} + RND;
        return r >>> SHIFT;
    endfunction

    // Returns {clip, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [DATA_W:0] q);
        if (q > QMAX)
            return {1'b1, 8'h7F};
        else if (q < QMIN)
            return {1'b1, 8'h80};
        else
            return {1'b0, q[OUT_W-1:0]};
    endfunction

    logic [3:0]               dcnt;
    logic                     capture;
    logic                     vld_p0;
    logic signed [DATA_W-1:0] y_p0;
    logic [OUT_W:0]           sat_p0;
    logic signed [OUT_W-1:0]  sample_p1;
    logic                     vld_p1;
    logic                     clip_p1;

    assign capture = io.ready_in && (dcnt == DCNT_LAST);

    // Stage p0: decimation counter and capture of the FIR word
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dcnt   <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= capture;
            if (io.ready_in)
                dcnt <= capture ? 4'd0 : dcnt + 4'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (capture)
            y_p0 <= io.y_in;
    end

    assign sat_p0 = saturate(round_shift(y_p0));

    // Stage p1: rescaled, saturated sample held between valid pulses
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sample_p1 <= '0;
            vld_p1    <= 1'b0;
            clip_p1   <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            clip_p1 <= vld_p0 & sat_p0[OUT_W];
            if (vld_p0)
                sample_p1 <= $signed(sat_p0[OUT_W-1:0]);
        end
    end

    assign io.sample_out       = sample_p1;
    assign io.sample_valid_out = vld_p1;
    assign io.clip_out         = clip_p1;

`ifdef PWM_OUT_EN
    logic [7:0] pcnt;
    logic [7:0] pending;
    logic [7:0] duty;
    logic       pwm_p2;

    // Pending is written at the end of the valid cycle, so a sample coinciding with
    // the wrap clock misses this reload and applies one period later.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pcnt    <= '0;
            pending <= 8'h80;
            duty    <= 8'h80;
            pwm_p2  <= 1'b0;
        end else begin
            pcnt   <= pcnt + 8'd1;
            pwm_p2 <= (pcnt < duty);
            if (vld_p1)
                pending <= $unsigned(sample_p1) ^ 8'h80;
            if (pcnt == 8'hFF)
                duty <= pending;
        end
    end

    assign io.pwm_out = pwm_p2;
`else
    assign io.pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_fir_decim_pwm.sv
// Directed bench for fir_decim_pwm: a DECIM=4 and a DECIM=1 instance share clock and reset.
module tb_fir_decim_pwm;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;

    fir_decim_pwm_if if4 ();
    fir_decim_pwm_if if1 ();

    fir_decim_pwm #(.DECIM(4), .SHIFT(10)) dut4 (.clk_in(clk_in), .rst_n_in(rst_n_in), .io(if4));
    fir_decim_pwm #(.DECIM(1), .SHIFT(10)) dut1 (.clk_in(clk_in), .rst_n_in(rst_n_in), .io(if1));

    always #5 clk_in = ~clk_in;

`ifdef PWM_OUT_EN
    localparam bit PWM_ON = 1'b1;
`else
    localparam bit PWM_ON = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int vcnt4 = 0;

    always @(posedge clk_in)
        if (if4.sample_valid_out) vcnt4 <= vcnt4 + 1;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // One-cycle strobe; returns at the falling edge right after the capturing edge.
    task automatic strobe(input bit sel4, input int y);
        @(negedge clk_in);
        if (sel4) begin if4.ready_in = 1'b1; if4.y_in = 18'(y); end
        else      begin if1.ready_in = 1'b1; if1.y_in = 18'(y); end
        @(negedge clk_in);
        if4.ready_in = 1'b0;
        if1.ready_in = 1'b0;
    endtask

    task automatic conv1(input string tag, input int y, input int exp_s, input int exp_c);
        strobe(1'b0, y);
        @(negedge clk_in);
        chk({tag, "_vld"}, int'(if1.sample_valid_out), 1);
        chk({tag, "_smp"}, int'(if1.sample_out), exp_s);
        chk({tag, "_clp"}, int'(if1.clip_out), exp_c);
    endtask

    task automatic count_hi(input bit sel4, output int hi);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_in);
            hi += sel4 ? int'(if4.pwm_out) : int'(if1.pwm_out);
        end
    endtask

    task automatic pwm_case(input string tag, input int y, input int exp_hi);
        int hi;
        strobe(1'b0, y);
        repeat (600) @(negedge clk_in);
        count_hi(1'b0, hi);
        chk(tag, hi, PWM_ON ? exp_hi : 0);
    endtask

    initial begin
        int v0;
        int hi;
        if4.ready_in = 1'b0; if4.y_in = '0;
        if1.ready_in = 1'b0; if1.y_in = '0;

        repeat (2) @(negedge clk_in);
        chk("rst_smp", int'(if4.sample_out), 0);
        chk("rst_vld", int'(if4.sample_valid_out), 0);
        chk("rst_clp", int'(if4.clip_out), 0);
        chk("rst_pwm", int'(if4.pwm_out), 0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        // DECIM=4: four strobes, a single pulse one clock after the fourth
        v0 = vcnt4;
        for (int i = 0; i < 4; i++) strobe(1'b1, 1024);
        chk("d4_early", int'(if4.sample_valid_out), 0);
        @(negedge clk_in);
        chk("d4_vld", int'(if4.sample_valid_out), 1);
        chk("d4_smp", int'(if4.sample_out), 1);
        chk("d4_clp", int'(if4.clip_out), 0);
        @(negedge clk_in);
        chk("d4_vld_off", int'(if4.sample_valid_out), 0);
        chk("d4_hold", int'(if4.sample_out), 1);
        chk("d4_pulses", vcnt4 - v0, 1);

        // DECIM=1: rounding half up
        conv1("r511",   511,    0, 0);
        conv1("r512",   512,    1, 0);
        conv1("rm512",  -512,   0, 0);
        conv1("rm513",  -513,  -1, 0);
        conv1("rm1536", -1536, -1, 0);

        // Saturation boundaries; -131072 rounds to exactly -128, inside range
        conv1("smax", 131071,  127, 1);
        @(negedge clk_in);
        chk("clp_off", int'(if1.clip_out), 0);
        conv1("smin", -131072, -128, 0);
        conv1("sedge", 130559, 127, 0);

        // PWM duty: mid-scale, full-scale, zero
        pwm_case("pwm_0",    0,       128);
        pwm_case("pwm_127",  130048,  255);
        pwm_case("pwm_m128", -131072, 0);

        // Reset mid-decimation
        strobe(1'b1, 1024);
        strobe(1'b1, 1024);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("mr_smp", int'(if4.sample_out), 0);
        chk("mr_vld", int'(if4.sample_valid_out), 0);
        chk("mr_clp", int'(if4.clip_out), 0);
        chk("mr_pwm", int'(if4.pwm_out), 0);
        rst_n_in = 1'b1;
        count_hi(1'b1, hi);
        chk("mr_duty", hi, PWM_ON ? 128 : 0);
        v0 = vcnt4;
        for (int i = 0; i < 3; i++) strobe(1'b1, 2048);
        repeat (2) @(negedge clk_in);
        chk("mr_nopulse", vcnt4 - v0, 0);
        strobe(1'b1, 2048);
        @(negedge clk_in);
        chk("mr_vld4", int'(if4.sample_valid_out), 1);
        chk("mr_smp4", int'(if4.sample_out), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
